// File: rtl/mux8_pkg.sv
// Shared constants and FSM state encoding for the 8-channel round-robin mux sequencer.
package mux8_pkg;

  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first asserted request scanning upward from last+1, wrapping 7->0.
module rr_pick8
  import mux8_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  logic             found;
  logic [SEL_W-1:0] idx;

  always_comb begin
    winner = last;
    any    = |req;
    found  = 1'b0;
    idx    = '0;
    // Offset 8 wraps back onto last itself, so the previous grant is checked last.
    for (int i = 1; i <= N_CH; i++) begin
      idx = last + SEL_W'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_sequencer.sv
// Round-robin sequencer driving an external 8:1 mux select and capturing its output for a ready/valid sink.
// Optional build macro MUX8_RR_FAST_PATH_EN: re-arbitrate straight from HOLD on transfer (2 cycles/word).
module mux8_rr_sequencer
  import mux8_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  req,
  output logic [SEL_W-1:0] select,
  input  logic [BITS-1:0]  mux_in,
  output logic [N_CH-1:0]  ack,
  output logic [BITS-1:0]  out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  state_t           state, state_nx;
  logic [SEL_W-1:0] last, last_nx;
  logic [SEL_W-1:0] select_nx;
  logic [BITS-1:0]  data_nx;
  logic             valid_nx;
  logic [N_CH-1:0]  ack_nx;
  logic [SEL_W-1:0] winner;
  logic             any;

  rr_pick8 u_pick (
    .req    (req),
    .last   (last),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last      <= SEL_W'(N_CH - 1);
      select    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      ack       <= '0;
    end else begin
      state     <= state_nx;
      last      <= last_nx;
      select    <= select_nx;
      out_data  <= data_nx;
      out_valid <= valid_nx;
      ack       <= ack_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    last_nx   = last;
    select_nx = select;
    data_nx   = out_data;
    valid_nx  = out_valid;
    ack_nx    = '0;
    case (state)
      IDLE: begin
        if (any) begin
          select_nx = winner;
          state_nx  = CAPTURE;
        end
      end
      CAPTURE: begin
        // Sources hold data until acked, so capture does not re-check req here.
        data_nx        = mux_in;
        valid_nx       = 1'b1;
        ack_nx[select] = 1'b1;
        last_nx        = select;
        state_nx       = HOLD;
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          valid_nx = 1'b0;
          state_nx = IDLE;
`ifdef MUX8_RR_FAST_PATH_EN
          if (any) begin
            select_nx = winner;
            state_nx  = CAPTURE;
          end
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux8_rr_sequencer.sv
// Scoreboard bench for mux8_rr_sequencer: queued source words, round-robin reference order, decoupled monitor.
module tb_mux8_rr_sequencer;

  localparam int BITS = 8;
`ifdef MUX8_RR_FAST_PATH_EN
  localparam int SPACING = 2;
`else
  localparam int SPACING = 3;
`endif

  typedef struct {
    int              ch;
    logic [BITS-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      req;
  logic [2:0]      select;
  logic [BITS-1:0] mux_in;
  logic [7:0]      ack;
  logic [BITS-1:0] out_data;
  logic            out_valid;
  logic            out_ready;

  logic [BITS-1:0] src_data [8];
  logic [BITS-1:0] src_q    [8][$];
  logic [BITS-1:0] stage_q  [8][$];
  exp_t            exp_q[$];
  exp_t            cur;
  int              rise_q[$];
  int              model_last;
  int              ready_mode;
  int              n_cmp = 0;
  int              n_err = 0;
  int              cyc = 0;
  int              xfers = 0;
  logic            prev_valid = 1'b0;

  mux8_rr_sequencer #(.BITS(BITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .select    (select),
    .mux_in    (mux_in),
    .ack       (ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign mux_in = src_data[select];

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference order: repeatedly take the next channel after the last grant that still has words queued.
  task automatic commit();
    int   rem[8];
    int   k[8];
    int   tot;
    int   c;
    exp_t e;
    tot = 0;
    c = 0;
    for (int i = 0; i < 8; i++) begin
      rem[i] = stage_q[i].size();
      k[i] = 0;
      tot += rem[i];
    end
    while (tot > 0) begin
      for (int d = 1; d <= 8; d++) begin
        c = (model_last + d) % 8;
        if (rem[c] > 0) break;
      end
      e.ch = c;
      e.data = stage_q[c][k[c]];
      exp_q.push_back(e);
      k[c]++;
      rem[c]--;
      tot--;
      model_last = c;
    end
    for (int i = 0; i < 8; i++) begin
      foreach (stage_q[i][j]) src_q[i].push_back(stage_q[i][j]);
      stage_q[i].delete();
    end
  endtask

  function automatic bit sources_busy();
    bit b = 1'b0;
    for (int i = 0; i < 8; i++) if (src_q[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic wait_quiet();
    int t = 0;
    while ((exp_q.size() != 0 || out_valid || sources_busy()) && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("quiet_timeout", 32'(t < 3000), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!out_valid && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("valid_timeout", 32'(t < 200), 32'd1);
  endtask

  // Monitor, source models and sink ready, all evaluated away from the rising edge.
  initial begin
    logic [7:0] oh;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        if (out_valid && !prev_valid) begin
          rise_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            chk("unexpected_word", {24'd0, out_data}, 32'hFFFF_FFFF);
          end else begin
            cur = exp_q.pop_front();
            oh = 8'h01 << cur.ch;
            chk("word_data", {24'd0, out_data}, {24'd0, cur.data});
            chk("word_ack", {24'd0, ack}, {24'd0, oh});
            chk("word_select", {29'd0, select}, 32'(cur.ch));
          end
        end else begin
          chk("ack_idle", {24'd0, ack}, 32'd0);
          if (out_valid) chk("hold_data", {24'd0, out_data}, {24'd0, cur.data});
        end
        prev_valid = out_valid;
      end else begin
        prev_valid = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
        if (ack[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        req[i] = (src_q[i].size() != 0);
        src_data[i] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
      end
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
      if (out_valid && out_ready) xfers++;
    end
  end

  initial begin
    int x0;
    int tot;
    rst = 1'b0;
    req = '0;
    out_ready = 1'b1;
    ready_mode = 0;
    model_last = 7;
    for (int i = 0; i < 8; i++) src_data[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_select", {29'd0, select}, 32'd0);
    chk("rst_ack", {24'd0, ack}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    #1 rst = 1'b1;

    // Single requester on channel 3.
    @(posedge clk); #1;
    stage_q[3].push_back(8'hA5);
    commit();
    wait_quiet();

    // Asynchronous reset while a word is held.
    ready_mode = 2;
    stage_q[5].push_back(8'h3C);
    commit();
    wait_valid();
    #1 rst = 1'b0;
    #1;
    chk("midrst_select", {29'd0, select}, 32'd0);
    chk("midrst_ack", {24'd0, ack}, 32'd0);
    chk("midrst_out_data", {24'd0, out_data}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    exp_q.delete();
    for (int i = 0; i < 8; i++) src_q[i].delete();
    model_last = 7;
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;

    // All eight requesting for two full rounds, starting at channel 0.
    for (int i = 0; i < 8; i++) begin
      stage_q[i].push_back(8'($urandom));
      stage_q[i].push_back(8'($urandom));
    end
    commit();
    wait_quiet();

    // Wrap between channels 7 and 0 (last grant was 7).
    stage_q[0].push_back(8'($urandom));
    stage_q[0].push_back(8'($urandom));
    stage_q[7].push_back(8'($urandom));
    commit();
    wait_quiet();

    // Backpressure: ten stalled cycles, then exactly one transfer.
    ready_mode = 2;
    stage_q[2].push_back(8'($urandom));
    commit();
    wait_valid();
    x0 = xfers;
    repeat (10) @(posedge clk);
    #1;
    chk("bp_valid_held", {31'd0, out_valid}, 32'd1);
    chk("bp_no_xfer", 32'(xfers - x0), 32'd0);
    ready_mode = 0;
    wait_quiet();
    chk("bp_one_xfer", 32'(xfers - x0), 32'd1);

    // Word spacing with a single persistent requester and ready tied high.
    rise_q.delete();
    for (int k = 0; k < 4; k++) stage_q[0].push_back(8'($urandom));
    commit();
    wait_quiet();
    chk("spacing_words", 32'(rise_q.size()), 32'd4);
    for (int k = 1; k < rise_q.size(); k++)
      chk("word_spacing", 32'(rise_q[k] - rise_q[k-1]), 32'(SPACING));

    // Randomised request sets and sink readiness.
    for (int p = 0; p < 25; p++) begin
      ready_mode = int'($urandom_range(0, 1));
      tot = 0;
      for (int i = 0; i < 8; i++) begin
        int n;
        n = int'($urandom_range(0, 3));
        tot += n;
        for (int k = 0; k < n; k++) stage_q[i].push_back(8'($urandom));
      end
      if (tot == 0) stage_q[$urandom_range(0, 7)].push_back(8'($urandom));
      commit();
      wait_quiet();
    end

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
